// File: rtl/instr_seq_fsm_pkg.sv
// Shared definitions for the instruction sequencer: opcodes, ALU codes,
// FSM state encoding and the decoded-instruction record.
package instr_seq_fsm_pkg;

    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_TRAP = 4'b1111;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_AND  = 2'b01;
    localparam logic [1:0] ALU_NOT  = 2'b10;
    localparam logic [1:0] ALU_PASS = 2'b11;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        BRWAIT = 3'd3,
        HALT   = 3'd4
    } seq_state_t;

    // Everything the sequencer needs out of one instruction word
    typedef struct packed {
        logic [1:0]  alu_op;
        logic [2:0]  dr;
        logic [2:0]  sr1;
        logic [2:0]  sr2;
        logic        imm_sel;
        logic [15:0] imm5;
        logic [2:0]  nzp;
        logic [15:0] br_off;
        logic        is_alu;
        logic        is_br;
        logic        is_trap;
        logic        is_illegal;
    } ir_fields_t;

    function automatic logic [15:0] sext5(input logic [4:0] v);
        return {{11{v[4]}}, v};
    endfunction

    function automatic logic [15:0] sext9(input logic [8:0] v);
        return {{7{v[8]}}, v};
    endfunction

endpackage

// File: rtl/instr_seq_fsm_ir_field_decode.sv
// Combinational instruction-register decode: opcode class, register
// fields, ALU op and sign-extended immediates.
module ir_field_decode
    import instr_seq_fsm_pkg::*;
(
    input  logic [15:0] ir,
    output ir_fields_t  fields
);

    logic [3:0] opcode;
    assign opcode = ir[15:12];

    // Classify the opcode and slice out the fields; unsupported opcodes become NOPs
    always_comb begin
        fields            = '0;
        fields.alu_op     = ALU_PASS;
        fields.dr         = ir[11:9];
        fields.sr1        = ir[8:6];
        fields.sr2        = ir[2:0];
        fields.imm5       = sext5(ir[4:0]);
        fields.nzp        = ir[11:9];
        fields.br_off     = sext9(ir[8:0]);
        case (opcode)
            OP_ADD: begin
                fields.is_alu  = 1'b1;
                fields.alu_op  = ALU_ADD;
                fields.imm_sel = ir[5];
            end
            OP_AND: begin
                fields.is_alu  = 1'b1;
                fields.alu_op  = ALU_AND;
                fields.imm_sel = ir[5];
            end
            OP_NOT: begin
                fields.is_alu  = 1'b1;
                fields.alu_op  = ALU_NOT;
            end
            OP_BR:   fields.is_br      = 1'b1;
            OP_TRAP: fields.is_trap    = 1'b1;
            default: fields.is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_seq_fsm.sv
// Fetch/decode/execute sequencer for a small LC-3 style subset. Owns the
// PC, drives register-file controls and hands BR masks to the NZP FSM,
// whose decision is sampled BR_WAIT cycles after the br_out pulse.
module instr_seq_fsm
    import instr_seq_fsm_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h3000,
    parameter int unsigned BR_WAIT  = 2
) (
    input  logic        clka,
    input  logic        reset_in,
    output logic        fetch_req_out,
    output logic [15:0] fetch_addr_out,
    input  logic        fetch_ack_in,
    input  logic [15:0] instr_in,
    output logic [15:0] pc_out,
    output logic        we_reg_out,
    output logic [1:0]  alu_op_out,
    output logic [2:0]  dr_out,
    output logic [2:0]  sr1_out,
    output logic [2:0]  sr2_out,
    output logic        imm_sel_out,
    output logic [15:0] imm5_out,
    output logic        n_dec_out,
    output logic        z_dec_out,
    output logic        p_dec_out,
    output logic        br_out,
    input  logic        pc_ctl_0_in,
    output logic        illegal_out,
    output logic        halted_out
);

    localparam int CW = (BR_WAIT > 1) ? $clog2(BR_WAIT) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(BR_WAIT - 1);

    seq_state_t  state;
    logic [15:0] ir;
    logic [CW-1:0] wait_cnt;
    ir_fields_t  fields;

    ir_field_decode u_dec (
        .ir     (ir),
        .fields (fields)
    );

    assign fetch_addr_out = pc_out;

    // Sequencer: outputs are registered so pulses line up with the state they belong to
    always_ff @(posedge clka or posedge reset_in) begin
        if (reset_in) begin
            state         <= FETCH;
            pc_out        <= RESET_PC;
            ir            <= '0;
            wait_cnt      <= '0;
            fetch_req_out <= 1'b0;
            we_reg_out    <= 1'b0;
            br_out        <= 1'b0;
            illegal_out   <= 1'b0;
            halted_out    <= 1'b0;
            alu_op_out    <= '0;
            dr_out        <= '0;
            sr1_out       <= '0;
            sr2_out       <= '0;
            imm_sel_out   <= 1'b0;
            imm5_out      <= '0;
            n_dec_out     <= 1'b0;
            z_dec_out     <= 1'b0;
            p_dec_out     <= 1'b0;
        end else begin
            we_reg_out  <= 1'b0;
            br_out      <= 1'b0;
            illegal_out <= 1'b0;
            case (state)
                FETCH: begin
                    // Handshake only counts once the request is actually visible
                    if (fetch_req_out && fetch_ack_in) begin
                        ir            <= instr_in;
                        pc_out        <= pc_out + 16'd1;
                        fetch_req_out <= 1'b0;
                        state         <= DECODE;
                    end else begin
                        fetch_req_out <= 1'b1;
                    end
                end
                DECODE: begin
                    alu_op_out  <= fields.alu_op;
                    dr_out      <= fields.dr;
                    sr1_out     <= fields.sr1;
                    sr2_out     <= fields.sr2;
                    imm_sel_out <= fields.imm_sel;
                    imm5_out    <= fields.imm5;
                    n_dec_out   <= fields.nzp[2];
                    z_dec_out   <= fields.nzp[1];
                    p_dec_out   <= fields.nzp[0];
                    we_reg_out  <= fields.is_alu;
                    br_out      <= fields.is_br;
                    illegal_out <= fields.is_illegal;
                    state       <= EXEC;
                end
                EXEC: begin
                    if (fields.is_br) begin
                        wait_cnt <= '0;
                        state    <= BRWAIT;
                    end else if (fields.is_trap) begin
                        halted_out <= 1'b1;
                        state      <= HALT;
                    end else begin
                        fetch_req_out <= 1'b1;
                        state         <= FETCH;
                    end
                end
                BRWAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        if (pc_ctl_0_in)
                            pc_out <= pc_out + fields.br_off;
                        fetch_req_out <= 1'b1;
                        state         <= FETCH;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                HALT: begin
                    halted_out    <= 1'b1;
                    fetch_req_out <= 1'b0;
                end
                default: begin
                    fetch_req_out <= 1'b1;
                    state         <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_seq_fsm.sv
// Directed bench for instr_seq_fsm: instance a uses the default RESET_PC,
// instance b starts at FFFF to exercise PC wrap-around.
module tb_instr_seq_fsm;

    logic        clka = 1'b0;
    logic        reset_in = 1'b1;
    logic        reset_b = 1'b1;
    logic        fetch_ack = 1'b0;
    logic [15:0] instr = '0;
    logic        pc_ctl = 1'b0;

    logic        fetch_req, we_reg, imm_sel, n_dec, z_dec, p_dec, br, illegal, halted;
    logic [15:0] fetch_addr, pc, imm5;
    logic [1:0]  alu_op;
    logic [2:0]  dr, sr1, sr2;

    logic        fetch_req_b, we_reg_b, imm_sel_b, n_dec_b, z_dec_b, p_dec_b, br_b, illegal_b, halted_b;
    logic [15:0] fetch_addr_b, pc_b, imm5_b;
    logic [1:0]  alu_op_b;
    logic [2:0]  dr_b, sr1_b, sr2_b;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clka = ~clka;

    instr_seq_fsm dut_a (
        .clka(clka), .reset_in(reset_in),
        .fetch_req_out(fetch_req), .fetch_addr_out(fetch_addr),
        .fetch_ack_in(fetch_ack), .instr_in(instr), .pc_out(pc),
        .we_reg_out(we_reg), .alu_op_out(alu_op), .dr_out(dr), .sr1_out(sr1),
        .sr2_out(sr2), .imm_sel_out(imm_sel), .imm5_out(imm5),
        .n_dec_out(n_dec), .z_dec_out(z_dec), .p_dec_out(p_dec), .br_out(br),
        .pc_ctl_0_in(pc_ctl), .illegal_out(illegal), .halted_out(halted)
    );

    instr_seq_fsm #(.RESET_PC(16'hFFFF), .BR_WAIT(2)) dut_b (
        .clka(clka), .reset_in(reset_b),
        .fetch_req_out(fetch_req_b), .fetch_addr_out(fetch_addr_b),
        .fetch_ack_in(fetch_ack), .instr_in(instr), .pc_out(pc_b),
        .we_reg_out(we_reg_b), .alu_op_out(alu_op_b), .dr_out(dr_b), .sr1_out(sr1_b),
        .sr2_out(sr2_b), .imm_sel_out(imm_sel_b), .imm5_out(imm5_b),
        .n_dec_out(n_dec_b), .z_dec_out(z_dec_b), .p_dec_out(p_dec_b), .br_out(br_b),
        .pc_ctl_0_in(pc_ctl), .illegal_out(illegal_b), .halted_out(halted_b)
    );

    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for the request, then complete one fetch handshake
    task automatic do_fetch(input bit use_b, input logic [15:0] word);
        int n = 0;
        while (((use_b ? fetch_req_b : fetch_req) !== 1'b1) && n < 50) begin
            tick();
            n++;
        end
        check("fetch_req_wait", {15'd0, use_b ? fetch_req_b : fetch_req}, 16'd1);
        fetch_ack = 1'b1;
        instr     = word;
        tick();
        fetch_ack = 1'b0;
        instr     = '0;
    endtask

    task automatic do_reset_a();
        reset_in = 1'b1;
        tick();
        reset_in = 1'b0;
        tick();
    endtask

    initial begin
        int bad;

        // ---- 1: reset state, then ADD R1,R2,#-3
        tick();
        check("rst_pc", pc, 16'h3000);
        check("rst_fetch_req", {15'd0, fetch_req}, 16'd0);
        check("rst_halted", {15'd0, halted}, 16'd0);
        check("rst_we_br", {14'd0, we_reg, br}, 16'd0);
        reset_in = 1'b0;
        tick();
        check("t1_req_rise", {15'd0, fetch_req}, 16'd1);
        check("t1_addr", fetch_addr, 16'h3000);
        do_fetch(1'b0, 16'h12BD);
        check("t1_pc_inc", pc, 16'h3001);
        check("t1_req_drop", {15'd0, fetch_req}, 16'd0);
        tick();
        check("t1_we", {15'd0, we_reg}, 16'd1);
        check("t1_br", {15'd0, br}, 16'd0);
        check("t1_alu", {14'd0, alu_op}, 16'd0);
        check("t1_dr", {13'd0, dr}, 16'd1);
        check("t1_sr1", {13'd0, sr1}, 16'd2);
        check("t1_sr2", {13'd0, sr2}, 16'd5);
        check("t1_imm_sel", {15'd0, imm_sel}, 16'd1);
        check("t1_imm5", imm5, 16'hFFFD);
        tick();
        check("t1_we_pulse", {15'd0, we_reg}, 16'd0);
        check("t1_next_addr", fetch_addr, 16'h3001);

        // ---- 2: BRz +5 taken; decision only sampled in the last wait cycle
        do_reset_a();
        do_fetch(1'b0, 16'h0405);
        tick();
        check("t2_br", {15'd0, br}, 16'd1);
        check("t2_nzp", {13'd0, n_dec, z_dec, p_dec}, 16'b010);
        check("t2_no_we", {15'd0, we_reg}, 16'd0);
        pc_ctl = 1'b0;
        tick();
        check("t2_br_pulse", {15'd0, br}, 16'd0);
        check("t2_pc_hold", pc, 16'h3001);
        fetch_ack = 1'b1;
        instr     = 16'h1000;
        tick();
        fetch_ack = 1'b0;
        pc_ctl    = 1'b1;
        tick();
        pc_ctl = 1'b0;
        check("t2_pc_taken", pc, 16'h3006);
        check("t2_req", {15'd0, fetch_req}, 16'd1);
        check("t2_addr", fetch_addr, 16'h3006);

        // ---- 3: same branch, not taken at the sample point
        do_reset_a();
        do_fetch(1'b0, 16'h0405);
        tick();
        tick();
        pc_ctl = 1'b1;
        tick();
        pc_ctl = 1'b0;
        tick();
        check("t3_pc_not_taken", pc, 16'h3001);
        check("t3_addr", fetch_addr, 16'h3001);
        tick();
        tick();
        check("t3_wait_no_ack", pc, 16'h3001);
        check("t3_req_held", {15'd0, fetch_req}, 16'd1);

        // ---- 4: NOT R3,R4 then TRAP -> HALT
        do_fetch(1'b0, 16'h973F);
        check("t4_pc", pc, 16'h3002);
        tick();
        check("t4_we", {15'd0, we_reg}, 16'd1);
        check("t4_alu", {14'd0, alu_op}, 16'd2);
        check("t4_dr", {13'd0, dr}, 16'd3);
        check("t4_sr1", {13'd0, sr1}, 16'd4);
        do_fetch(1'b0, 16'hF025);
        tick();
        check("t4_trap_exec", {13'd0, we_reg, illegal, halted}, 16'd0);
        tick();
        check("t4_halted", {15'd0, halted}, 16'd1);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            fetch_ack = i[0];
            tick();
            if (fetch_req !== 1'b0 || halted !== 1'b1) bad++;
        end
        fetch_ack = 1'b0;
        check("t4_halt_20cyc_bad", bad[15:0], 16'd0);
        check("t4_halt_pc", pc, 16'h3003);

        // ---- 5: instance b, PC wrap both ways, then illegal opcode
        check("t5_rst_pc", pc_b, 16'hFFFF);
        reset_b = 1'b0;
        tick();
        check("t5_addr", fetch_addr_b, 16'hFFFF);
        do_fetch(1'b1, 16'h0FFF);
        check("t5_pc_wrap", pc_b, 16'h0000);
        tick();
        check("t5_br", {15'd0, br_b}, 16'd1);
        check("t5_nzp", {13'd0, n_dec_b, z_dec_b, p_dec_b}, 16'b111);
        pc_ctl = 1'b1;
        tick();
        tick();
        tick();
        pc_ctl = 1'b0;
        check("t5_pc_back", pc_b, 16'hFFFF);
        do_fetch(1'b1, 16'hD000);
        check("t5_pc_wrap2", pc_b, 16'h0000);
        tick();
        check("t5_illegal", {15'd0, illegal_b}, 16'd1);
        check("t5_no_we_br", {14'd0, we_reg_b, br_b}, 16'd0);
        tick();
        check("t5_illegal_pulse", {15'd0, illegal_b}, 16'd0);
        check("t5_next_addr", fetch_addr_b, 16'h0000);
        reset_b = 1'b1;

        // ---- 6: asynchronous reset from HALT, mid-BRWAIT and mid-fetch
        reset_in = 1'b1;
        #2;
        check("t6_halt_clear", {15'd0, halted}, 16'd0);
        check("t6_halt_pc", pc, 16'h3000);
        tick();
        reset_in = 1'b0;
        tick();
        do_fetch(1'b0, 16'h0405);
        tick();
        tick();
        pc_ctl = 1'b1;
        #2;
        reset_in = 1'b1;
        #1;
        check("t6_brwait_pc", pc, 16'h3000);
        check("t6_brwait_req", {15'd0, fetch_req}, 16'd0);
        tick();
        tick();
        check("t6_brwait_pc_hold", pc, 16'h3000);
        reset_in = 1'b0;
        pc_ctl   = 1'b0;
        tick();
        check("t6_req_after", {15'd0, fetch_req}, 16'd1);
        do_fetch(1'b0, 16'h12BD);
        tick();
        tick();
        tick();
        check("t6_fetch_pc", pc, 16'h3001);
        #2;
        reset_in = 1'b1;
        #1;
        check("t6_fetch_req_clear", {15'd0, fetch_req}, 16'd0);
        check("t6_fetch_pc_rst", pc, 16'h3000);
        tick();
        reset_in = 1'b0;
        tick();
        check("t6_final_req", {15'd0, fetch_req}, 16'd1);
        check("t6_final_addr", fetch_addr, 16'h3000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
